wos_rank_window: RTL

Sliding-window weighted order statistic (WOS) engine for the rank-order filter datapath. It keeps the last N accepted samples with an incrementally maintained rank per sample, ranking each new sample with N-1 parallel compares per insert rather than by sorting. It selects the output as the weighted order statistic set by per-age weights and a threshold. Ready/valid on both sides lets it sit between the sample source and the filter output stage, and it replaces the fixed-median ranker.

---
 rtl/wos_pkg.sv | 25 ++
 rtl/wos_rank_cell.sv | 47 ++++
 rtl/wos_rank_window.sv | 129 ++++++++++++
 3 files changed

// File: rtl/wos_pkg.sv
// Shared width helpers for the rank-order filter datapath.
package wos_pkg;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) result++;
    return result;
  endfunction

  function automatic int unsigned rank_bits(input int unsigned n);
    return clog2(n);
  endfunction

  // Wide enough for N full-scale weights, so sums never wrap.
  function automatic int unsigned sum_bits(input int unsigned weight_bits, input int unsigned n);
    return weight_bits + clog2(n + 1);
  endfunction

  localparam int unsigned DefaultN          = 5;
  localparam int unsigned DefaultWeightBits = 3;
  localparam int unsigned DefaultRankBits   = rank_bits(DefaultN);
  localparam int unsigned DefaultSumBits    = sum_bits(DefaultWeightBits, DefaultN);

endpackage

// File: rtl/wos_rank_cell.sv
// One window position: sample and rank registers plus the survivor rank update.
module wos_rank_cell #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned RANK_BITS = 3,
  parameter int unsigned INDEX     = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 shift_i,
  input  logic [DATA_BITS-1:0] in_data_i,
  input  logic [RANK_BITS-1:0] evict_rank_i,
  input  logic [DATA_BITS-1:0] prev_data_i,
  input  logic [RANK_BITS-1:0] prev_rank_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic [RANK_BITS-1:0] rank_o,
  output logic [RANK_BITS-1:0] upd_rank_o,
  output logic                 le_o
);

  logic [DATA_BITS-1:0] data_q;
  logic [RANK_BITS-1:0] rank_q;
  logic                 new_below;
  logic                 evict_below;

  assign new_below   = in_data_i < data_q;
  assign evict_below = rank_q > evict_rank_i;
  assign le_o        = data_q <= in_data_i;
  // Modular arithmetic is safe: the net result always lies in 0..N-1.
  assign upd_rank_o  = rank_q + RANK_BITS'(new_below) - RANK_BITS'(evict_below);
  assign data_o      = data_q;
  assign rank_o      = rank_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      rank_q <= RANK_BITS'(INDEX);
    end else if (clear_i) begin
      data_q <= '0;
      rank_q <= RANK_BITS'(INDEX);
    end else if (shift_i) begin
      data_q <= prev_data_i;
      rank_q <= prev_rank_i;
    end
  end

endmodule

// File: rtl/wos_rank_window.sv
// Sliding-window weighted order statistic with incremental ranking and a single output register.
module wos_rank_window
  import wos_pkg::*;
#(
  parameter  int unsigned DATA_BITS   = 8,
  parameter  int unsigned N           = 5,
  parameter  int unsigned WEIGHT_BITS = 3,
  localparam int unsigned RANK_BITS   = rank_bits(N),
  localparam int unsigned SUM_BITS    = sum_bits(WEIGHT_BITS, N)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [DATA_BITS-1:0]       in_data_i,
  input  logic [N*WEIGHT_BITS-1:0]   weights_i,
  input  logic [SUM_BITS-1:0]        threshold_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [DATA_BITS-1:0]       out_data_o
);

  localparam int unsigned FillBits = clog2(N + 1);

  logic [DATA_BITS-1:0]   cell_data [N];
  logic [RANK_BITS-1:0]   cell_rank [N];
  logic [RANK_BITS-1:0]   cell_upd  [N];
  logic [N-1:0]           cell_le;
  logic [DATA_BITS-1:0]   data_n    [N];
  logic [RANK_BITS-1:0]   rank_n    [N];
  logic [WEIGHT_BITS-1:0] weight    [N];
  logic [SUM_BITS-1:0]    cum_w     [N];
  logic [SUM_BITS-1:0]    below_w   [N];
  logic [RANK_BITS-1:0]   new_rank;
  logic [DATA_BITS-1:0]   sel_data;
  logic [FillBits-1:0]    fill_q, fill_d;
  logic                   out_valid_q;
  logic [DATA_BITS-1:0]   out_data_q;
  logic                   accept;
  logic                   full_d;
  logic                   unused_tail;

  assign in_ready_o  = !out_valid_q || out_ready_i;
  assign accept      = in_valid_i && in_ready_o && !clear_i;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign unused_tail = ^{cell_le[N-1], cell_upd[N-1]};

  for (genvar i = 0; i < N; i++) begin : g_cell
    wos_rank_cell #(
      .DATA_BITS (DATA_BITS),
      .RANK_BITS (RANK_BITS),
      .INDEX     (i)
    ) u_cell (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .clear_i      (clear_i),
      .shift_i      (accept),
      .in_data_i    (in_data_i),
      .evict_rank_i (cell_rank[N-1]),
      .prev_data_i  (data_n[i]),
      .prev_rank_i  (rank_n[i]),
      .data_o       (cell_data[i]),
      .rank_o       (cell_rank[i]),
      .upd_rank_o   (cell_upd[i]),
      .le_o         (cell_le[i])
    );
  end

  // Post-shift window: position 0 takes the new sample, the rest take updated survivors.
  always_comb begin
    new_rank = '0;
    for (int i = 0; i < N - 1; i++) new_rank = new_rank + RANK_BITS'(cell_le[i]);
    data_n[0] = in_data_i;
    rank_n[0] = new_rank;
    for (int i = 1; i < N; i++) begin
      data_n[i] = cell_data[i-1];
      rank_n[i] = cell_upd[i-1];
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      weight[i]  = weights_i[i*WEIGHT_BITS +: WEIGHT_BITS];
      cum_w[i]   = '0;
      for (int j = 0; j < N; j++) begin
        if (rank_n[j] <= rank_n[i]) cum_w[i] = cum_w[i] + SUM_BITS'(weight[j]);
      end
      below_w[i] = cum_w[i] - SUM_BITS'(weight[i]);
    end
  end

  // A sample wins when its cumulative weight first reaches T; default covers T above the total.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (rank_n[i] == RANK_BITS'(N - 1)) sel_data = data_n[i];
    end
    for (int i = 0; i < N; i++) begin
      if (cum_w[i] >= threshold_i && (rank_n[i] == '0 || below_w[i] < threshold_i)) begin
        sel_data = data_n[i];
      end
    end
  end

  assign fill_d = (fill_q == FillBits'(N)) ? fill_q : fill_q + 1'b1;
  assign full_d = fill_d == FillBits'(N);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (clear_i) begin
      fill_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (accept) fill_q <= fill_d;
      if (accept && full_d) begin
        out_valid_q <= 1'b1;
        out_data_q  <= sel_data;
      end else if (out_ready_i && out_valid_q) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule
